tachyon_schematic_compactor: RTL and testbench
==============================================

Name: tachyon_schematic_compactor

Overview:
- Upstream stage of the tachyon manifold simulator.
- Accepts the raw schematic as an ASCII byte stream with valid/ready.
- Drops redundant all-empty lines so the emitted stream is: the S line, then strictly alternating empty and splitter lines.
- Replays each kept line as one-hot strobes (empty/enter/splitter/line_feed plus valid) that feed the simulator directly.

Parameters:
TACHYON_MANIFOLD_WIDTH, 3, characters per schematic line excluding LF; odd, >= 3; must match the simulator's parameter.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
char_in  input  8  ASCII byte from input source
char_in_valid  input  1  char_in is valid
char_in_ready  output  1  byte accepted when valid & ready on a rising edge
beam_empty  output  1  emitted '.'
beam_enter  output  1  emitted 'S'
beam_splitter  output  1  emitted '^'
beam_line_feed  output  1  emitted end of line
beam_in_valid  output  1  strobes above are valid this cycle; no backpressure from the simulator
compact_done  output  1  sticky; last required line has been emitted
compact_error  output  1  sticky; malformed input detected

Behaviour:
- Reset, asynchronous and active-high: state=FILL, col=0, emitted_lines=0, last_kept_empty=0, line buffer cleared.
- All outputs reset to 0 except char_in_ready, which is 1 in FILL.
- All beam_* outputs are registered and mutually exclusive. beam_in_valid=0 implies all strobes are 0.
- Character codes:
  - 0x2E '.' stores EMPTY.
  - 0x53 'S' stores ENTER.
  - 0x5E '^' stores SPLIT.
  - 0x0A LF ends the line.
  - 0x0D CR is accepted and ignored.
  - Any other byte sets the error.
- Line buffer: W entries x 2 bits. col counter is $clog2(W+1) bits wide.
- Line classification is done at LF:
  - mark_line = line contains S or ^.
  - A line with S is legal only as input line 0.
- States:
  - FILL:
    - char_in_ready=1.
    - A character at col<W is stored and col increments.
    - A character arriving when col==W sets the error.
    - LF with col!=W sets the error.
    - LF with col==W applies the keep rule, then col is cleared.
  - Keep rule:
    - Line 0 must contain exactly one S (else error) and is always kept.
    - An empty line is kept iff the last kept line was a mark line; otherwise it is silently dropped and the state stays FILL.
    - A ^ line is kept iff the last kept line was empty; otherwise error.
  - REPLAY:
    - Entered on the cycle after a kept LF is accepted.
    - char_in_ready=0.
    - Emits W buffer entries (index 0 first), then one LF, one per cycle with beam_in_valid=1. That is W+1 consecutive valid cycles.
    - After the LF cycle:
      - emitted_lines increments.
      - If emitted_lines reaches 2*MAX_Y+1, where MAX_Y=(W-1)/2, go to DONE.
      - Otherwise return to FILL, with char_in_ready=1 on the next cycle.
  - DONE:
    - compact_done=1.
    - char_in_ready=1; all further bytes are consumed and discarded, including trailing empty lines.
    - No beam output.
  - ERROR:
    - compact_error=1.
    - char_in_ready=1; input is discarded.
    - No further beam output.
    - Held until reset.
    - An error detected at an LF suppresses that line's replay.
- Latency:
  - The first replayed character is valid 1 cycle after the kept LF handshake.
  - Minimum line period is (W+1) accept cycles + (W+1) replay cycles.
- Simultaneous events: char_in_valid is ignored whenever char_in_ready=0. Bytes are not lost because source stalls.
- Reset mid-REPLAY: output ceases immediately (async). Partial line is discarded.

Test Plan:
1. W=3. Input ".S.\n...\n.^.\n...\n" -> beam stream: E,S,E,LF; E,E,E,LF; E,^,E,LF. compact_done=1 after the 12th valid cycle. Trailing "...\n" consumed with no output. compact_error=0.
2. W=7. Input "...S...\n.......\n.......\n...^...\n" -> second empty line dropped; 3 lines x 8 valid cycles emitted. char_in_ready=0 exactly during each 8-cycle replay.
3. W=3. Input ".S.\r\n...\r\n.^.\r\n" -> identical output to case 1. CRs produce no beam strobes.
4. W=3. Input ".S.\n..\n" -> compact_error=1 at the second LF. Only the first line (4 valid cycles) is emitted. Later bytes are accepted with no output.
5. W=3. Input ".S.\n.^.\n" -> error: a ^ line follows a mark line directly. Similarly, "...\n" as line 0 -> error at the first LF.
6. W=5. Assert reset on the 3rd replay cycle of line 0 -> all outputs 0 immediately. Replaying the full valid file afterwards produces the complete correct stream.

Source files
------------

// File: rtl/tachyon_schematic_compactor.sv
// Schematic compactor: buffers one ASCII schematic line, drops redundant empty lines,
// and replays each kept line as one-hot beam strobes for the manifold simulator.
module tachyon_schematic_compactor #(
  parameter int TACHYON_MANIFOLD_WIDTH = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] char_in,
  input  logic       char_in_valid,
  output logic       char_in_ready,
  output logic       beam_empty,
  output logic       beam_enter,
  output logic       beam_splitter,
  output logic       beam_line_feed,
  output logic       beam_in_valid,
  output logic       compact_done,
  output logic       compact_error
);

  localparam int W     = TACHYON_MANIFOLD_WIDTH;
  localparam int COL_W = $clog2(W + 1);
  localparam int MAX_Y = (W - 1) / 2;
  localparam int LINES = 2 * MAX_Y + 1;

  localparam logic [COL_W-1:0] COL_FULL  = COL_W'(W);
  localparam logic [COL_W-1:0] LAST_LINE = COL_W'(LINES - 1);

  localparam logic [7:0] CH_DOT   = 8'h2E;
  localparam logic [7:0] CH_S     = 8'h53;
  localparam logic [7:0] CH_CARET = 8'h5E;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_ENTER = 2'd1,
    CELL_SPLIT = 2'd2
  } cell_t;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_REPLAY,
    ST_DONE,
    ST_ERROR
  } state_t;

  function automatic logic is_cell_char(input logic [7:0] ch);
    return (ch == CH_DOT) || (ch == CH_S) || (ch == CH_CARET);
  endfunction

  function automatic cell_t cell_of(input logic [7:0] ch);
    cell_t c;
    case (ch)
      CH_S:     c = CELL_ENTER;
      CH_CARET: c = CELL_SPLIT;
      default:  c = CELL_EMPTY;
    endcase
    return c;
  endfunction

  // Strobe vector layout: {line_feed, splitter, enter, empty}.
  function automatic logic [3:0] strobe_of(input cell_t c);
    logic [3:0] s;
    case (c)
      CELL_ENTER: s = 4'b0010;
      CELL_SPLIT: s = 4'b0100;
      default:    s = 4'b0001;
    endcase
    return s;
  endfunction

  state_t           state;
  cell_t            line_buf [W];
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] emitted_lines;
  logic             last_kept_empty;
  logic [1:0]       s_cnt;
  logic             has_split;
  logic             lf_sent;
  logic [3:0]       beam_q;
  logic             beam_vld;

  logic first_line;
  logic line_is_mark;
  logic lf_keep;
  logic lf_err;

  assign first_line   = (emitted_lines == '0);
  assign line_is_mark = (s_cnt != 2'd0) || has_split;

  // Keep/drop/error decision for the line being terminated by an LF.
  always_comb begin
    lf_keep = 1'b0;
    lf_err  = 1'b0;
    if (col != COL_FULL) begin
      lf_err = 1'b1;
    end else if (first_line) begin
      if (s_cnt == 2'd1) lf_keep = 1'b1;
      else               lf_err  = 1'b1;
    end else if (s_cnt != 2'd0) begin
      lf_err = 1'b1;
    end else if (has_split) begin
      if (last_kept_empty) lf_keep = 1'b1;
      else                 lf_err  = 1'b1;
    end else if (!last_kept_empty) begin
      lf_keep = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_FILL;
      col             <= '0;
      emitted_lines   <= '0;
      last_kept_empty <= 1'b0;
      s_cnt           <= 2'd0;
      has_split       <= 1'b0;
      lf_sent         <= 1'b0;
      for (int i = 0; i < W; i++) line_buf[i] <= CELL_EMPTY;
      char_in_ready   <= 1'b1;
      beam_q          <= 4'b0000;
      beam_vld        <= 1'b0;
      compact_done    <= 1'b0;
      compact_error   <= 1'b0;
    end else begin
      beam_q   <= 4'b0000;
      beam_vld <= 1'b0;
      case (state)
        ST_FILL: begin
          if (char_in_valid) begin
            if (char_in == CH_LF) begin
              s_cnt     <= 2'd0;
              has_split <= 1'b0;
              if (lf_err) begin
                col           <= '0;
                state         <= ST_ERROR;
                compact_error <= 1'b1;
              end else if (lf_keep) begin
                // Entry 0 goes out on the edge that accepts the LF.
                state           <= ST_REPLAY;
                char_in_ready   <= 1'b0;
                last_kept_empty <= !line_is_mark;
                beam_q          <= strobe_of(line_buf[0]);
                beam_vld        <= 1'b1;
                col             <= COL_W'(1);
              end else begin
                col <= '0;
              end
            end else if (char_in == CH_CR) begin
              col <= col;
            end else if (!is_cell_char(char_in) || (col == COL_FULL)) begin
              state         <= ST_ERROR;
              compact_error <= 1'b1;
            end else begin
              line_buf[col] <= cell_of(char_in);
              col           <= col + COL_W'(1);
              if (cell_of(char_in) == CELL_ENTER && s_cnt != 2'd2) s_cnt <= s_cnt + 2'd1;
              if (cell_of(char_in) == CELL_SPLIT) has_split <= 1'b1;
            end
          end
        end

        ST_REPLAY: begin
          if (!lf_sent) begin
            beam_vld <= 1'b1;
            if (col == COL_FULL) begin
              beam_q  <= 4'b1000;
              lf_sent <= 1'b1;
            end else begin
              beam_q <= strobe_of(line_buf[col]);
              col    <= col + COL_W'(1);
            end
          end else begin
            // Cycle after the LF strobe: reopen the input.
            lf_sent       <= 1'b0;
            col           <= '0;
            emitted_lines <= emitted_lines + COL_W'(1);
            char_in_ready <= 1'b1;
            if (emitted_lines == LAST_LINE) begin
              state        <= ST_DONE;
              compact_done <= 1'b1;
            end else begin
              state <= ST_FILL;
            end
          end
        end

        default: begin
          state <= state;
        end
      endcase
    end
  end

  assign beam_empty     = beam_q[0];
  assign beam_enter     = beam_q[1];
  assign beam_splitter  = beam_q[2];
  assign beam_line_feed = beam_q[3];
  assign beam_in_valid  = beam_vld;

endmodule

// File: tb/tb_tachyon_schematic_compactor.sv
// Bench for tachyon_schematic_compactor: three widths (3, 5, 7) driven with directed
// and random schematics, compared against a line-level reference model.
module tb_tachyon_schematic_compactor;

  localparam int NI = 3;

  logic       clk;
  logic       reset;
  logic [7:0] ci  [NI];
  logic       cv  [NI];
  logic       rdy [NI];
  logic       bem [NI];
  logic       ben [NI];
  logic       bsp [NI];
  logic       blf [NI];
  logic       bv  [NI];
  logic       dn  [NI];
  logic       er  [NI];

  int    vectors = 0;
  int    miscompares = 0;
  string got [NI];

  tachyon_schematic_compactor #(.TACHYON_MANIFOLD_WIDTH(3)) u_w3 (
    .clk(clk), .reset(reset), .char_in(ci[0]), .char_in_valid(cv[0]), .char_in_ready(rdy[0]),
    .beam_empty(bem[0]), .beam_enter(ben[0]), .beam_splitter(bsp[0]), .beam_line_feed(blf[0]),
    .beam_in_valid(bv[0]), .compact_done(dn[0]), .compact_error(er[0]));

  tachyon_schematic_compactor #(.TACHYON_MANIFOLD_WIDTH(5)) u_w5 (
    .clk(clk), .reset(reset), .char_in(ci[1]), .char_in_valid(cv[1]), .char_in_ready(rdy[1]),
    .beam_empty(bem[1]), .beam_enter(ben[1]), .beam_splitter(bsp[1]), .beam_line_feed(blf[1]),
    .beam_in_valid(bv[1]), .compact_done(dn[1]), .compact_error(er[1]));

  tachyon_schematic_compactor #(.TACHYON_MANIFOLD_WIDTH(7)) u_w7 (
    .clk(clk), .reset(reset), .char_in(ci[2]), .char_in_valid(cv[2]), .char_in_ready(rdy[2]),
    .beam_empty(bem[2]), .beam_enter(ben[2]), .beam_splitter(bsp[2]), .beam_line_feed(blf[2]),
    .beam_in_valid(bv[2]), .compact_done(dn[2]), .compact_error(er[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wof(input int idx);
    return (idx == 0) ? 3 : ((idx == 1) ? 5 : 7);
  endfunction

  // Observe every instance away from the active edge; record strobes as text.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      vectors++;
      assert (rdy[i] === !bv[i]) else begin
        miscompares++;
        $error("FAIL ready_vs_valid inst=%0d observed ready=%0b valid=%0b, required ready=%0b",
               i, rdy[i], bv[i], !bv[i]);
      end
      vectors++;
      assert ($countones({blf[i], bsp[i], ben[i], bem[i]}) == (bv[i] ? 1 : 0)) else begin
        miscompares++;
        $error("FAIL strobe_onehot inst=%0d observed valid=%0b strobes=%b%b%b%b, required %0d strobe(s)",
               i, bv[i], blf[i], bsp[i], ben[i], bem[i], bv[i] ? 1 : 0);
      end
      if (bv[i] === 1'b1)
        got[i] = $sformatf("%s%s", got[i], blf[i] ? "|" : (bsp[i] ? "^" : (ben[i] ? "S" : ".")));
    end
  end

  // Reference: split into lines, apply keep rules, render kept lines with '|' for LF.
  function automatic void model(input int w, input string s, output string exp,
                                output bit edone, output bit eerr);
    string cur;
    int    kept;
    bit    last_mark;
    int    ns;
    int    nc;
    bit    keep;
    byte   c;
    exp = ""; edone = 0; eerr = 0; kept = 0; last_mark = 0; cur = "";
    for (int i = 0; i < s.len(); i++) begin
      if (edone || eerr) break;
      c = s[i];
      if (c == 8'h0D) continue;
      if (c != 8'h0A) begin
        if (c != 8'h2E && c != 8'h53 && c != 8'h5E) begin
          eerr = 1;
          break;
        end
        cur = $sformatf("%s%c", cur, c);
        continue;
      end
      ns = 0; nc = 0; keep = 0;
      for (int k = 0; k < cur.len(); k++) begin
        if (cur[k] == 8'h53) ns++;
        if (cur[k] == 8'h5E) nc++;
      end
      if (cur.len() != w)  eerr = 1;
      else if (kept == 0)  begin if (ns == 1) keep = 1; else eerr = 1; end
      else if (ns > 0)     eerr = 1;
      else if (nc > 0)     begin if (!last_mark) keep = 1; else eerr = 1; end
      else if (last_mark)  keep = 1;
      if (keep) begin
        exp = {exp, cur, "|"};
        kept++;
        last_mark = (ns + nc) > 0;
        if (kept == w) edone = 1;
      end
      cur = "";
    end
  endfunction

  function automatic string gen_file(input int w);
    string s;
    int    nlines;
    int    kind;
    int    pos;
    int    len;
    s = "";
    nlines = $urandom_range(2, 2 * w + 2);
    for (int l = 0; l < nlines; l++) begin
      if (l == 0) kind = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
      else begin
        kind = $urandom_range(0, 19);
        kind = (kind < 9) ? 1 : ((kind < 18) ? 2 : ((kind == 18) ? 3 : 0));
      end
      pos = $urandom_range(0, w - 1);
      len = w;
      if (kind == 3 && $urandom_range(0, 1) == 1) len = ($urandom_range(0, 1) == 1) ? w + 1 : w - 1;
      for (int k = 0; k < len; k++) begin
        if (kind == 0 && k == pos)                                  s = {s, "S"};
        else if (kind == 2 && (k == pos || $urandom_range(0, 1) == 1)) s = {s, "^"};
        else if (kind == 3 && len == w && k == pos)                 s = {s, "x"};
        else                                                        s = {s, "."};
      end
      if ($urandom_range(0, 3) == 0) s = {s, "\015"};
      s = {s, "\n"};
    end
    return s;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_str(input string tag, input string obs, input string exp);
    vectors++;
    assert (obs == exp) else begin
      miscompares++;
      $error("FAIL %s observed=\"%s\" expected=\"%s\"", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_byte(input int idx, input logic [7:0] b);
    int guard;
    guard = 0;
    ci[idx] = b;
    cv[idx] = 1'b1;
    while (rdy[idx] !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      vectors++;
      miscompares++;
      $error("FAIL handshake_timeout inst=%0d observed ready=%0b, required 1 within 200 cycles", idx, rdy[idx]);
    end
    @(negedge clk);
    cv[idx] = 1'b0;
  endtask

  task automatic send_str(input int idx, input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(idx, s[i]);
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic finish_case(input int idx, input string s, input string tag);
    string exp;
    bit    edone;
    bit    eerr;
    repeat (2 * wof(idx) + 6) @(negedge clk);
    model(wof(idx), s, exp, edone, eerr);
    check_str({tag, "_stream"}, got[idx], exp);
    check_bit({tag, "_done"}, dn[idx], edone);
    check_bit({tag, "_error"}, er[idx], eerr);
  endtask

  task automatic run_case(input int idx, input string s, input string tag);
    pulse_reset();
    got[idx] = "";
    send_str(idx, s, 1'b1);
    finish_case(idx, s, tag);
  endtask

  initial begin
    string f1;
    string f6;
    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      ci[i] = 8'h00;
      cv[i] = 1'b0;
      got[i] = "";
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check_bit($sformatf("reset_ready_%0d", i), rdy[i], 1'b1);
      check_bit($sformatf("reset_valid_%0d", i), bv[i], 1'b0);
      check_bit($sformatf("reset_done_%0d", i), dn[i], 1'b0);
      check_bit($sformatf("reset_error_%0d", i), er[i], 1'b0);
    end

    // Case 1: W=3 full file with trailing empty line; first strobe one cycle after the LF.
    f1 = ".S.\n...\n.^.\n...\n";
    pulse_reset();
    got[0] = "";
    send_str(0, ".S.", 1'b0);
    send_byte(0, 8'h0A);
    check_bit("c1_first_valid", bv[0], 1'b1);
    check_bit("c1_first_empty", bem[0], 1'b1);
    check_bit("c1_ready_low", rdy[0], 1'b0);
    send_str(0, "...\n.^.\n...\n", 1'b1);
    finish_case(0, f1, "c1");
    check_str("c1_literal", got[0], ".S.|...|.^.|");

    // Case 2: W=7, consecutive empty lines collapse.
    run_case(2, "...S...\n.......\n.......\n...^...\n", "c2");
    check_str("c2_literal", got[2], "...S...|.......|...^...|");

    // Case 3: CRLF line endings.
    run_case(0, ".S.\015\n...\015\n.^.\015\n", "c3");
    check_str("c3_literal", got[0], ".S.|...|.^.|");
    check_bit("c3_done", dn[0], 1'b1);

    // Case 4: short line; later bytes must still be consumed.
    run_case(0, ".S.\n..\n.^.\n", "c4");
    check_str("c4_literal", got[0], ".S.|");
    check_bit("c4_error", er[0], 1'b1);

    // Case 5: splitter right after mark line, and a line 0 without S.
    run_case(0, ".S.\n.^.\n", "c5a");
    check_bit("c5a_error", er[0], 1'b1);
    run_case(0, "...\n", "c5b");
    check_bit("c5b_error", er[0], 1'b1);
    check_str("c5b_literal", got[0], "");

    // Case 6: W=5, reset during the 3rd replay cycle of line 0.
    f6 = "..S..\n.....\n..^..\n.....\n.^.^.\n.....\n";
    pulse_reset();
    got[1] = "";
    send_str(1, "..S..\n", 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_bit("c6_in_replay", bv[1], 1'b1);
    #1 reset = 1'b1;
    #1;
    check_bit("c6_valid_cut", bv[1], 1'b0);
    check_bit("c6_enter_cut", ben[1], 1'b0);
    check_bit("c6_empty_cut", bem[1], 1'b0);
    check_bit("c6_lf_cut", blf[1], 1'b0);
    check_bit("c6_ready_reset", rdy[1], 1'b1);
    @(negedge clk);
    reset = 1'b0;
    run_case(1, f6, "c6");
    check_str("c6_literal", got[1], "..S..|.....|..^..|.....|.^.^.|");
    check_bit("c6_done", dn[1], 1'b1);

    // Random schematics on every width.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NI; i++) begin
        run_case(i, gen_file(wof(i)), $sformatf("rand%0d_w%0d", r, wof(i)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
